fft_inplace_sequencer: RTL and testbench

- Address/control sequencer for an in-place, memory-based radix-2 DIF FFT of N = 2^LOG2N points, sharing one pipelined butterfly unit across all stages.
- Sequences four phases: load frame into the sample RAM; issue all butterflies of every stage (read pair, twiddle index, delayed write-back); drain the pipeline between stages; stream the result out in natural order via bit-reversed reads.
- Sits between the input stream, the sample RAM (synchronous write, asynchronous read), the butterfly pipeline and the output stream. It carries no data.

---
 rtl/fft_ctrl_pkg.sv | 17 +
 rtl/fft_inplace_sequencer_if.sv | 37 +++
 rtl/fft_wb_delay.sv | 28 ++
 rtl/fft_inplace_sequencer.sv | 102 ++++++++++
 tb/tb_fft_inplace_sequencer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: shared state encoding, default sizes and helpers for the FFT sequencer
package fft_ctrl_pkg;
  localparam int DEF_LOG2N = 3;
  localparam int DEF_BF_LATENCY = 4;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_OUTPUT} fft_seq_state_e;
  function automatic int stage_w(int lg);
    return lg > 1 ? $clog2(lg) : 1;
  endfunction
  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [31:0] bitrev(logic [31:0] v, int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (i < w) r[5'(i)] = v[5'(w - 1 - i)];
    return r;
  endfunction
endpackage

// File: rtl/fft_inplace_sequencer_if.sv
// fft_inplace_sequencer_if: stream, RAM-address and butterfly control bundle of the FFT sequencer
interface fft_inplace_sequencer_if
  import fft_ctrl_pkg::*;
#(
  parameter int LOG2N = DEF_LOG2N
);
  localparam int SW = stage_w(LOG2N);
  logic             in_valid_i;
  logic             in_ready_o;
  logic             ld_we_o;
  logic [LOG2N-1:0] ld_addr_o;
  logic             bf_issue_o;
  logic [LOG2N-1:0] bf_addr_a_o;
  logic [LOG2N-1:0] bf_addr_b_o;
  logic [LOG2N-2:0] bf_tw_o;
  logic             wb_en_o;
  logic [LOG2N-1:0] wb_addr_a_o;
  logic [LOG2N-1:0] wb_addr_b_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [LOG2N-1:0] out_rd_addr_o;
  logic             out_last_o;
  logic [SW-1:0]    stage_o;
  logic             busy_o;
  modport master (
    input  in_valid_i, out_ready_i,
    output in_ready_o, ld_we_o, ld_addr_o, bf_issue_o, bf_addr_a_o, bf_addr_b_o, bf_tw_o,
           wb_en_o, wb_addr_a_o, wb_addr_b_o, out_valid_o, out_rd_addr_o, out_last_o,
           stage_o, busy_o
  );
  modport slave (
    output in_valid_i, out_ready_i,
    input  in_ready_o, ld_we_o, ld_addr_o, bf_issue_o, bf_addr_a_o, bf_addr_b_o, bf_tw_o,
           wb_en_o, wb_addr_a_o, wb_addr_b_o, out_valid_o, out_rd_addr_o, out_last_o,
           stage_o, busy_o
  );
endinterface

// File: rtl/fft_wb_delay.sv
// fft_wb_delay: DEPTH-stage delay line aligning write-back strobe/addresses with butterfly output
module fft_wb_delay
  import fft_ctrl_pkg::*;
#(
  parameter int W = DEF_LOG2N,
  parameter int DEPTH = DEF_BF_LATENCY
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         en_o,
  output logic [W-1:0] a_o,
  output logic [W-1:0] b_o
);
  logic [2*W:0] sr_d [DEPTH];
  logic [2*W:0] sr_q [DEPTH];
  always_comb begin
    sr_d[0] = {en_i, a_i, b_i};
    for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
  end
  // Clearing the whole line on reset kills any write-back still in flight.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) sr_q <= '{default: '0};
    else sr_q <= sr_d;
  assign {en_o, a_o, b_o} = sr_q[DEPTH-1];
endmodule

// File: rtl/fft_inplace_sequencer.sv
// fft_inplace_sequencer: load / per-stage butterfly issue / drain / bit-reversed output
// sequencing for an in-place radix-2 DIF FFT sharing one pipelined butterfly.
module fft_inplace_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter int LOG2N = DEF_LOG2N,
  parameter int BF_LATENCY = DEF_BF_LATENCY
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  fft_inplace_sequencer_if.master bus
);
  localparam int N = 1 << LOG2N;
  localparam int SW = stage_w(LOG2N);
  localparam int DW = BF_LATENCY > 1 ? $clog2(BF_LATENCY) : 1;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] HALF_LAST = LOG2N'(N / 2 - 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(LOG2N - 1);
  localparam logic [DW-1:0] DLAST = DW'(BF_LATENCY - 1);
  fft_seq_state_e   state_q, state_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [LOG2N-1:0] span, k, a;
  logic             iss, ld_hs, out_hs;
  // a = 2*g*span + k rewritten as 2*(p-k) + k since g*span is p with its low bits cleared.
  always_comb begin
    span = LOG2N'(N >> (32'(stage_q) + 1));
    k = cnt_q & (span - 1'b1);
    a = ((cnt_q - k) << 1) + k;
    iss = state_q == S_ISSUE;
    ld_hs = state_q == S_LOAD && bus.in_valid_i;
    out_hs = state_q == S_OUTPUT && bus.out_ready_i;
    bus.in_ready_o = state_q == S_LOAD;
    bus.ld_we_o = ld_hs;
    bus.ld_addr_o = state_q == S_LOAD ? cnt_q : '0;
    bus.bf_issue_o = iss;
    bus.bf_addr_a_o = iss ? a : '0;
    bus.bf_addr_b_o = iss ? a + span : '0;
    bus.bf_tw_o = iss ? (LOG2N-1)'(k << stage_q) : '0;
    bus.out_valid_o = state_q == S_OUTPUT;
    bus.out_rd_addr_o = state_q == S_OUTPUT ? LOG2N'(bitrev(32'(cnt_q), LOG2N)) : '0;
    bus.out_last_o = state_q == S_OUTPUT && cnt_q == LAST;
    bus.stage_o = stage_q;
    bus.busy_o = state_q inside {S_ISSUE, S_DRAIN, S_OUTPUT};
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    stage_d = stage_q;
    dcnt_d = dcnt_q;
    case (state_q)
      S_IDLE: state_d = S_LOAD;
      S_LOAD: if (ld_hs) begin
        cnt_d = cnt_q == LAST ? '0 : cnt_q + 1'b1;
        stage_d = '0;
        state_d = cnt_q == LAST ? S_ISSUE : S_LOAD;
      end
      S_ISSUE: begin
        cnt_d = cnt_q == HALF_LAST ? '0 : cnt_q + 1'b1;
        dcnt_d = '0;
        state_d = cnt_q == HALF_LAST ? S_DRAIN : S_ISSUE;
      end
      // Draining BF_LATENCY cycles lands the stage's last write-back before the next stage reads.
      S_DRAIN: begin
        dcnt_d = dcnt_q == DLAST ? '0 : dcnt_q + 1'b1;
        if (dcnt_q == DLAST) begin
          state_d = stage_q == LAST_STAGE ? S_OUTPUT : S_ISSUE;
          stage_d = stage_q == LAST_STAGE ? stage_q : stage_q + 1'b1;
        end
      end
      S_OUTPUT: if (out_hs) begin
        cnt_d = cnt_q == LAST ? '0 : cnt_q + 1'b1;
        stage_d = cnt_q == LAST ? '0 : stage_q;
        state_d = cnt_q == LAST ? S_LOAD : S_OUTPUT;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      stage_q <= '0;
      dcnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      stage_q <= stage_d;
      dcnt_q <= dcnt_d;
    end
  fft_wb_delay #(.W(LOG2N), .DEPTH(BF_LATENCY)) u_wb_delay (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en_i (bus.bf_issue_o),
    .a_i  (bus.bf_addr_a_o),
    .b_i  (bus.bf_addr_b_o),
    .en_o (bus.wb_en_o),
    .a_o  (bus.wb_addr_a_o),
    .b_o  (bus.wb_addr_b_o)
  );
endmodule

// File: tb/tb_fft_inplace_sequencer.sv
// tb_fft_inplace_sequencer: table-driven and randomized checks of the FFT sequencer at
// N=8/latency 4 and N=16/latency 2 against a formula-level reference model.
module tb_fft_inplace_sequencer;
  logic clk = 1'b0;
  logic rst1, rst2;
  always #5 clk = ~clk;
  fft_inplace_sequencer_if #(.LOG2N(3)) b1();
  fft_inplace_sequencer_if #(.LOG2N(4)) b2();
  fft_inplace_sequencer #(.LOG2N(3), .BF_LATENCY(4)) dut1 (.clk_i(clk), .rst_i(rst1), .bus(b1.master));
  fft_inplace_sequencer #(.LOG2N(4), .BF_LATENCY(2)) dut2 (.clk_i(clk), .rst_i(rst2), .bus(b2.master));
  int checks = 0;
  int failures = 0;
  typedef struct {int a; int b; int tw;} bf_vec_t;
  typedef struct {bit ready; int addr; bit last;} out_vec_t;
  bf_vec_t stage_tab[12];
  out_vec_t out_tab[15];
  int out_order[8];
  int first16[4];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int bitrev_ref(int v, int lg);
    int r = 0;
    for (int i = 0; i < lg; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  task automatic pair(int n, int s, int p, output int a, output int b, output int tw);
    int span = n >> (s + 1);
    a = (p / span) * 2 * span + p % span;
    b = a + span;
    tw = (p % span) << s;
  endtask

  task automatic reset1();
    @(negedge clk);
    rst1 = 1'b1; b1.in_valid_i = 1'b0; b1.out_ready_i = 1'b0;
    #1;
    chk("rst_in_ready", int'(b1.in_ready_o), 0);
    chk("rst_busy", int'(b1.busy_o), 0);
    chk("rst_issue", int'(b1.bf_issue_o), 0);
    chk("rst_wb_en", int'(b1.wb_en_o), 0);
    chk("rst_out_valid", int'(b1.out_valid_o), 0);
    chk("rst_stage", int'(b1.stage_o), 0);
    @(negedge clk);
    rst1 = 1'b0;
    #1;
    chk("idle_in_ready", int'(b1.in_ready_o), 0);
  endtask

  task automatic load1(int gap_pct);
    int n = 0;
    int g = 0;
    while (n < 8 && g < 200) begin
      @(negedge clk);
      b1.in_valid_i = ($urandom_range(99) >= gap_pct);
      #1;
      chk("ld_ready", int'(b1.in_ready_o), 1);
      chk("ld_we", int'(b1.ld_we_o), int'(b1.in_valid_i));
      if (b1.in_valid_i) begin
        chk("ld_addr", int'(b1.ld_addr_o), n);
        n++;
      end
      g++;
    end
    if (n < 8) chk("ld_timeout", n, 8);
  endtask

  task automatic compute1(int use_tab, int stop);
    int s, q, t2, ea, eb, etw;
    bit iss, wbe;
    for (int t = 0; t < stop; t++) begin
      @(negedge clk);
      b1.in_valid_i = 1'($urandom_range(1));
      #1;
      s = t / 8; q = t % 8; iss = q < 4;
      chk("c_issue", int'(b1.bf_issue_o), int'(iss));
      if (iss) begin
        if (use_tab != 0) begin
          ea = stage_tab[s*4+q].a; eb = stage_tab[s*4+q].b; etw = stage_tab[s*4+q].tw;
        end else pair(8, s, q, ea, eb, etw);
        chk("c_addr_a", int'(b1.bf_addr_a_o), ea);
        chk("c_addr_b", int'(b1.bf_addr_b_o), eb);
        chk("c_tw", int'(b1.bf_tw_o), etw);
      end
      t2 = t - 4;
      wbe = t2 >= 0 && t2 % 8 < 4;
      chk("c_wb_en", int'(b1.wb_en_o), int'(wbe));
      if (wbe) begin
        pair(8, t2 / 8, t2 % 8, ea, eb, etw);
        chk("c_wb_a", int'(b1.wb_addr_a_o), ea);
        chk("c_wb_b", int'(b1.wb_addr_b_o), eb);
      end
      chk("c_stage", int'(b1.stage_o), s);
      chk("c_busy", int'(b1.busy_o), 1);
      chk("c_in_ready", int'(b1.in_ready_o), 0);
      chk("c_ld_we", int'(b1.ld_we_o), 0);
      chk("c_out_valid", int'(b1.out_valid_o), 0);
    end
  endtask

  task automatic output1(int mode);
    int n = 0;
    int g = 0;
    if (mode == 0) begin
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        b1.out_ready_i = out_tab[i].ready;
        b1.in_valid_i = 1'($urandom_range(1));
        #1;
        chk("o_valid", int'(b1.out_valid_o), 1);
        chk("o_addr_tab", int'(b1.out_rd_addr_o), out_tab[i].addr);
        chk("o_last_tab", int'(b1.out_last_o), int'(out_tab[i].last));
        chk("o_ld_we", int'(b1.ld_we_o), 0);
      end
    end else begin
      while (n < 8 && g < 300) begin
        @(negedge clk);
        b1.out_ready_i = 1'($urandom_range(1));
        b1.in_valid_i = 1'($urandom_range(1));
        #1;
        chk("o_valid", int'(b1.out_valid_o), 1);
        chk("o_addr", int'(b1.out_rd_addr_o), bitrev_ref(n, 3));
        chk("o_last", int'(b1.out_last_o), int'(n == 7));
        chk("o_busy", int'(b1.busy_o), 1);
        if (b1.out_ready_i) n++;
        g++;
      end
      if (n < 8) chk("o_timeout", n, 8);
    end
    @(negedge clk);
    b1.out_ready_i = 1'b0; b1.in_valid_i = 1'b0;
    #1;
    chk("post_in_ready", int'(b1.in_ready_o), 1);
    chk("post_out_valid", int'(b1.out_valid_o), 0);
    chk("post_busy", int'(b1.busy_o), 0);
  endtask

  task automatic mid_reset1();
    #1 rst1 = 1'b1;
    b1.in_valid_i = 1'b0; b1.out_ready_i = 1'b0;
    #1;
    chk("ar_issue", int'(b1.bf_issue_o), 0);
    chk("ar_addr_a", int'(b1.bf_addr_a_o), 0);
    chk("ar_wb_en", int'(b1.wb_en_o), 0);
    chk("ar_busy", int'(b1.busy_o), 0);
    chk("ar_stage", int'(b1.stage_o), 0);
    chk("ar_in_ready", int'(b1.in_ready_o), 0);
    @(negedge clk);
    #1 chk("ar_wb_hold", int'(b1.wb_en_o), 0);
    @(negedge clk);
    rst1 = 1'b0;
    #1;
    chk("ar_wb_idle", int'(b1.wb_en_o), 0);
    chk("ar_idle_ready", int'(b1.in_ready_o), 0);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("ar_wb_load", int'(b1.wb_en_o), 0);
      chk("ar_load_ready", int'(b1.in_ready_o), 1);
    end
  endtask

  task automatic run_dut2();
    int s, q, t2, ea, eb, etw;
    bit iss, wbe;
    @(negedge clk);
    rst2 = 1'b0;
    #1 chk("d2_idle_ready", int'(b2.in_ready_o), 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      b2.in_valid_i = 1'b1;
      #1;
      chk("d2_ld_we", int'(b2.ld_we_o), 1);
      chk("d2_ld_addr", int'(b2.ld_addr_o), i);
    end
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      b2.in_valid_i = 1'b0;
      #1;
      s = t / 10; q = t % 10; iss = q < 8;
      chk("d2_issue", int'(b2.bf_issue_o), int'(iss));
      if (iss) begin
        pair(16, s, q, ea, eb, etw);
        chk("d2_addr_a", int'(b2.bf_addr_a_o), ea);
        chk("d2_addr_b", int'(b2.bf_addr_b_o), eb);
        chk("d2_tw", int'(b2.bf_tw_o), etw);
        if (s == 3) begin
          chk("d2_s3_a", int'(b2.bf_addr_a_o), 2 * q);
          chk("d2_s3_b", int'(b2.bf_addr_b_o), 2 * q + 1);
          chk("d2_s3_tw", int'(b2.bf_tw_o), 0);
        end
      end
      t2 = t - 2;
      wbe = t2 >= 0 && t2 % 10 < 8;
      chk("d2_wb_en", int'(b2.wb_en_o), int'(wbe));
      if (wbe) begin
        pair(16, t2 / 10, t2 % 10, ea, eb, etw);
        chk("d2_wb_a", int'(b2.wb_addr_a_o), ea);
        chk("d2_wb_b", int'(b2.wb_addr_b_o), eb);
      end
      chk("d2_stage", int'(b2.stage_o), s);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      b2.out_ready_i = 1'b1;
      #1;
      chk("d2_out_valid", int'(b2.out_valid_o), 1);
      chk("d2_out_addr", int'(b2.out_rd_addr_o), bitrev_ref(i, 4));
      if (i < 4) chk("d2_out_first", int'(b2.out_rd_addr_o), first16[i]);
      chk("d2_out_last", int'(b2.out_last_o), int'(i == 15));
    end
    @(negedge clk);
    b2.out_ready_i = 1'b0;
    #1 chk("d2_post_ready", int'(b2.in_ready_o), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    stage_tab = '{'{0, 4, 0}, '{1, 5, 1}, '{2, 6, 2}, '{3, 7, 3},
                  '{0, 2, 0}, '{1, 3, 2}, '{4, 6, 0}, '{5, 7, 2},
                  '{0, 1, 0}, '{2, 3, 0}, '{4, 5, 0}, '{6, 7, 0}};
    out_order = '{0, 4, 2, 6, 1, 5, 3, 7};
    first16 = '{0, 8, 4, 12};
    for (int i = 0; i < 15; i++)
      out_tab[i] = '{ready: (i % 2 == 0), addr: out_order[(i + 1) / 2], last: ((i + 1) / 2 == 7)};
    rst1 = 1'b1; rst2 = 1'b1;
    b1.in_valid_i = 1'b0; b1.out_ready_i = 1'b0;
    b2.in_valid_i = 1'b0; b2.out_ready_i = 1'b0;
    reset1();
    load1(0);
    compute1(1, 24);
    output1(0);
    load1(30);
    compute1(0, 24);
    output1(1);
    load1(50);
    compute1(0, 11);
    mid_reset1();
    load1(20);
    compute1(0, 24);
    output1(1);
    run_dut2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
